// File: rtl/freq_meter.sv
// freq_meter: counts synchronised rising edges of sig_in over a GATE_CYCLES window, strobes freq_valid per window.
// Optional period measurement enabled by defining FREQ_METER_PERIOD_EN.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W = 32,
  parameter int GATE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy,
  output logic [CNT_W-1:0] per_cnt,
  output logic             per_valid
);
  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;
  localparam logic [GATE_W-1:0] LAST = GATE_W'(GATE_CYCLES - 1);
  state_t state;
  logic meta_q, sync_q, prev_q, rise, sat;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  assign rise = sync_q & ~prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta_q, sync_q, prev_q} <= 3'b000;
    else {meta_q, sync_q, prev_q} <= {sig_in, meta_q, sync_q};
  // freq_cnt/freq_valid are loaded together on the LATCH edge, so the strobe and data coincide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat <= 1'b0;
      freq_cnt <= '0;
      freq_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE:
          if (meas_en) begin
            state <= GATE;
            busy <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat <= 1'b0;
          end
        GATE:
          if (!meas_en) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            if (rise) begin
              if (&edge_cnt) sat <= 1'b1;
              else edge_cnt <= edge_cnt + 1'b1;
            end
            if (gate_cnt == LAST) state <= LATCH;
            else gate_cnt <= gate_cnt + 1'b1;
          end
        LATCH: begin
          freq_cnt <= edge_cnt;
          overflow <= sat;
          freq_valid <= 1'b1;
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat <= 1'b0;
          state <= meas_en ? GATE : IDLE;
          busy <= meas_en;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_ctr;
  logic first_seen;
  // the first edge after enable only aligns the counter; later edges report the elapsed period
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      per_ctr <= '0;
      first_seen <= 1'b0;
      per_cnt <= '0;
      per_valid <= 1'b0;
    end else begin
      per_valid <= 1'b0;
      if (!meas_en) begin
        per_ctr <= '0;
        first_seen <= 1'b0;
      end else if (rise) begin
        per_ctr <= '0;
        first_seen <= 1'b1;
        if (first_seen) begin
          per_cnt <= (&per_ctr) ? per_ctr : per_ctr + 1'b1;
          per_valid <= 1'b1;
        end
      end else if (!(&per_ctr)) per_ctr <= per_ctr + 1'b1;
    end
`else
  assign per_cnt = '0;
  assign per_valid = 1'b0;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter with a 100-cycle gate, plus a 4-bit instance for saturation.
module tb_freq_meter;
  typedef struct {int cnt; bit ovf; bit lo_ok;} exp_t;
  logic clk = 0, rst = 1, sig_in = 0, meas_en = 0, en4 = 0;
  logic [31:0] freq_cnt, per_cnt;
  logic freq_valid, overflow, busy, per_valid;
  logic [3:0] freq_cnt4, per_cnt4;
  logic freq_valid4, overflow4, busy4, per_valid4;
  int pass = 0, total = 0, cyc = 0, per = 0, ph = 0;
  int nv = 0, nv4 = 0, vcyc = 0, vcyc4 = 0;
  bit per_nz = 0;
  exp_t q[$], q4[$];
  exp_t e, e4;
  freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .GATE_W(32)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .freq_cnt(freq_cnt), .freq_valid(freq_valid), .overflow(overflow), .busy(busy),
    .per_cnt(per_cnt), .per_valid(per_valid));
  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .GATE_W(8)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(en4),
    .freq_cnt(freq_cnt4), .freq_valid(freq_valid4), .overflow(overflow4), .busy(busy4),
    .per_cnt(per_cnt4), .per_valid(per_valid4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // square wave of period per clk (high for per/2), held low when per == 0
  initial forever begin
    @(negedge clk);
    ph = (per == 0) ? 0 : (ph + 1) % per;
    sig_in = (per != 0) && (ph < per / 2);
  end
  always @(negedge clk) if (!rst) begin
    if (per_valid || per_cnt != 0) per_nz = 1;
    if (freq_valid) begin
      nv++;
      vcyc = cyc;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid cnt=%0d ovf=%0b expected no strobe", freq_cnt, overflow);
      end else begin
        e = q.pop_front();
        total++;
        if (freq_cnt === 32'(e.cnt) || (e.lo_ok && freq_cnt === 32'(e.cnt - 1))) pass++;
        else $display("FAIL freq_cnt got=%0d exp=%0d", freq_cnt, e.cnt);
        total++;
        if (overflow === e.ovf) pass++;
        else $display("FAIL overflow got=%0b exp=%0b", overflow, e.ovf);
      end
    end
    if (freq_valid4) begin
      nv4++;
      vcyc4 = cyc;
      if (q4.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid4 cnt=%0d ovf=%0b expected no strobe", freq_cnt4, overflow4);
      end else begin
        e4 = q4.pop_front();
        total++;
        if (freq_cnt4 === 4'(e4.cnt)) pass++;
        else $display("FAIL freq_cnt4 got=%0d exp=%0d", freq_cnt4, e4.cnt);
        total++;
        if (overflow4 === e4.ovf) pass++;
        else $display("FAIL overflow4 got=%0b exp=%0b", overflow4, e4.ovf);
      end
    end
  end
  task automatic wait_nv(input bit four, input int target, input int budget);
    int n;
    n = 0;
    while (((four ? nv4 : nv) < target) && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if ((four ? nv4 : nv) >= target) pass++;
    else $display("FAIL wait_valid four=%0b got=%0d exp=%0d", four, four ? nv4 : nv, target);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({freq_cnt, freq_valid, overflow, busy, per_cnt, per_valid} === '0) pass++;
    else $display("FAIL reset_outputs got cnt=%0d v=%0b o=%0b b=%0b exp all 0", freq_cnt, freq_valid, overflow, busy);
    total++;
    if ({freq_cnt4, freq_valid4, overflow4, busy4, per_cnt4, per_valid4} === '0) pass++;
    else $display("FAIL reset_outputs4 got cnt=%0d b=%0b exp all 0", freq_cnt4, busy4);
    rst = 0;
    repeat (3) @(negedge clk);
    total++;
    if (busy === 1'b0) pass++;
    else $display("FAIL idle_busy got=%0b exp=0", busy);
  endtask
  task automatic test_count;
    int b, t0, last;
    per = 10;
    repeat (30) @(negedge clk);
    q.push_back('{10, 0, 1});
    q.push_back('{10, 0, 0});
    q.push_back('{10, 0, 0});
    b = nv;
    meas_en = 1;
    t0 = cyc;
    wait_nv(0, b + 1, 150);
    total++;
    if (vcyc - t0 == 102) pass++;
    else $display("FAIL first_latency got=%0d exp=102", vcyc - t0);
    last = vcyc;
    @(negedge clk);
    total++;
    if (busy === 1'b1) pass++;
    else $display("FAIL busy_running got=%0b exp=1", busy);
    for (int i = 2; i <= 3; i++) begin
      wait_nv(0, b + i, 150);
      total++;
      if (vcyc - last == 101) pass++;
      else $display("FAIL interval got=%0d exp=101", vcyc - last);
      last = vcyc;
    end
    @(negedge clk);
    meas_en = 0;
    repeat (2) @(negedge clk);
    total++;
    if (busy === 1'b0 && q.size() == 0) pass++;
    else $display("FAIL stop got busy=%0b pending=%0d exp busy=0 pending=0", busy, q.size());
  endtask
  task automatic test_zero;
    int b, last;
    per = 0;
    repeat (10) @(negedge clk);
    q.push_back('{0, 0, 0});
    q.push_back('{0, 0, 0});
    b = nv;
    meas_en = 1;
    wait_nv(0, b + 1, 150);
    last = vcyc;
    wait_nv(0, b + 2, 150);
    total++;
    if (vcyc - last == 101) pass++;
    else $display("FAIL zero_interval got=%0d exp=101", vcyc - last);
    @(negedge clk);
    meas_en = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_abort;
    int b, t0;
    per = 10;
    repeat (30) @(negedge clk);
    q.push_back('{10, 0, 1});
    b = nv;
    meas_en = 1;
    wait_nv(0, b + 1, 150);
    repeat (49) @(negedge clk);
    meas_en = 0;
    b = nv;
    repeat (2) @(negedge clk);
    total++;
    if (busy === 1'b0) pass++;
    else $display("FAIL abort_busy got=%0b exp=0", busy);
    repeat (150) @(negedge clk);
    total++;
    if (nv == b && freq_cnt === 32'd10) pass++;
    else $display("FAIL abort_hold got strobes=%0d cnt=%0d exp strobes=0 cnt=10", nv - b, freq_cnt);
    q.push_back('{10, 0, 1});
    meas_en = 1;
    t0 = cyc;
    wait_nv(0, b + 1, 150);
    total++;
    if (vcyc - t0 == 102) pass++;
    else $display("FAIL restart_latency got=%0d exp=102", vcyc - t0);
  endtask
  task automatic test_rst_mid;
    int b, t0;
    repeat (40) @(negedge clk);
    total++;
    if (busy === 1'b1 && freq_cnt === 32'd10) pass++;
    else $display("FAIL pre_rst got busy=%0b cnt=%0d exp busy=1 cnt=10", busy, freq_cnt);
    @(posedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({freq_cnt, freq_valid, overflow, busy} === '0) pass++;
    else $display("FAIL async_rst got cnt=%0d b=%0b exp all 0", freq_cnt, busy);
    repeat (2) @(negedge clk);
    q.push_back('{10, 0, 1});
    b = nv;
    rst = 0;
    t0 = cyc;
    wait_nv(0, b + 1, 150);
    total++;
    if (vcyc - t0 == 102) pass++;
    else $display("FAIL post_rst_latency got=%0d exp=102", vcyc - t0);
    @(negedge clk);
    meas_en = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_saturate;
    int b;
    per = 2;
    repeat (10) @(negedge clk);
    q4.push_back('{15, 1, 0});
    b = nv4;
    en4 = 1;
    wait_nv(1, b + 1, 150);
    @(negedge clk);
    en4 = 0;
    per = 20;
    repeat (40) @(negedge clk);
    q4.push_back('{5, 0, 0});
    en4 = 1;
    wait_nv(1, b + 2, 150);
    @(negedge clk);
    en4 = 0;
    repeat (3) @(negedge clk);
    total++;
    if (q4.size() == 0 && busy4 === 1'b0) pass++;
    else $display("FAIL sat_done got pending=%0d busy4=%0b exp 0/0", q4.size(), busy4);
  endtask
  task automatic test_period;
`ifdef FREQ_METER_PERIOD_EN
    int t0, last, np, n;
    per = 10;
    repeat (20) @(negedge clk);
    meas_en = 1;
    t0 = cyc;
    np = 0;
    n = 0;
    last = 0;
    while (np < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (per_valid) begin
        total++;
        if (np == 0 ? (cyc - t0 >= 11 && cyc - t0 <= 20) : (cyc - last == 10)) pass++;
        else $display("FAIL per_timing pulse=%0d got=%0d", np, np == 0 ? cyc - t0 : cyc - last);
        total++;
        if (per_cnt === 32'd10) pass++;
        else $display("FAIL per_cnt got=%0d exp=10", per_cnt);
        last = cyc;
        np++;
      end
    end
    total++;
    if (np == 4) pass++;
    else $display("FAIL per_pulses got=%0d exp=4", np);
    meas_en = 0;
    repeat (3) @(negedge clk);
`else
    per = 10;
    meas_en = 1;
    repeat (60) @(negedge clk);
    meas_en = 0;
    repeat (3) @(negedge clk);
    total++;
    if (!per_nz) pass++;
    else $display("FAIL per_tied got nonzero per_cnt/per_valid exp 0");
`endif
  endtask
  initial begin
    test_reset;
    test_count;
    test_zero;
    test_abort;
    test_rst_mid;
    test_saturate;
    test_period;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
